// File: rtl/subckt_stim_compactor.sv
// subckt_stim_compactor
//   Stimulus generator and response compactor for one benchmark sub-circuit.
//   A Galois LFSR drives one vector per cycle into the sub-circuit. Responses
//   come back RESP_LAT cycles later and are folded into a MISR. At the end of
//   a run the MISR is compared against a golden signature.
//
// Ports
//   tg_clk      sole clock, rising edge
//   tg_rst      asynchronous active-high reset
//   start       one-cycle pulse, begins a run (accepted only in IDLE)
//   abort       synchronous cancel of a run in progress
//   num_vec     vectors per run, sampled with start
//   golden      expected signature, sampled with start
//   stim        vector to the sub-circuit inputs
//   stim_valid  stim carries a new vector this cycle
//   resp        sub-circuit output
//   busy        run or drain in progress
//   done        one-cycle completion pulse
//   pass        final signature matched golden (held until next start)
//   signature   current MISR value
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last run's results
// RUN   | one vector per cycle, count down to the last vector
// DRAIN | no new vectors; wait RESP_LAT cycles for in-flight responses
// DONE  | single cycle: done pulse, pass reflects the final comparison
module subckt_stim_compactor #(
  parameter int                N_IN     = 9,
  parameter int                N_OUT    = 1,
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
  parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
  parameter int                MISR_W   = 16,
  parameter logic [MISR_W-1:0] POLY     = 16'h1021,
  parameter int                RESP_LAT = 2
) (
  input  logic              tg_clk,
  input  logic              tg_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       num_vec,
  input  logic [MISR_W-1:0] golden,
  output logic [N_IN-1:0]   stim,
  output logic              stim_valid,
  input  logic [N_OUT-1:0]  resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Drain timer counts RESP_LAT cycles down to zero.
  localparam logic [2:0] DRAIN_LOAD = 3'(RESP_LAT - 1);

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [MISR_W-1:0]   misr_q, misr_d;
  logic [MISR_W-1:0]   golden_q, golden_d;
  logic [15:0]         count_q, count_d;
  logic [RESP_LAT-1:0] vpipe_q, vpipe_d;
  logic [2:0]          drain_q, drain_d;
  logic [N_IN-1:0]     hold_q, hold_d;
  logic                pass_q, pass_d;

  logic [LFSR_W-1:0]   lfsr_step;
  logic [MISR_W-1:0]   misr_step;
  logic [MISR_W-1:0]   resp_ext;

  assign stim_valid = (state_q == S_RUN);
  // In RUN the live LFSR value is the vector; otherwise show the last one sent.
  assign stim       = (state_q == S_RUN) ? lfsr_q[N_IN-1:0] : hold_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign signature  = misr_q;

  always_comb begin
    resp_ext = '0;
    resp_ext[N_OUT-1:0] = resp;
    lfsr_step = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_step = lfsr_step ^ TAPS;
    misr_step = {misr_q[MISR_W-2:0], 1'b0} ^ resp_ext;
    if (misr_q[MISR_W-1]) misr_step = misr_step ^ POLY;
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    golden_d = golden_q;
    count_d  = count_q;
    drain_d  = drain_q;
    hold_d   = hold_q;
    pass_d   = pass_q;
    // Tail of the pipe marks the cycle whose resp answers a vector sent
    // RESP_LAT cycles earlier.
    vpipe_d  = RESP_LAT'({vpipe_q, stim_valid});
    if (vpipe_q[RESP_LAT-1]) misr_d = misr_step;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          count_d  = num_vec;
          golden_d = golden;
          lfsr_d   = SEED;
          misr_d   = '0;
          pass_d   = 1'b0;
          vpipe_d  = '0;
          if (num_vec == 16'd0) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LOAD;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        lfsr_d  = lfsr_step;
        hold_d  = lfsr_q[N_IN-1:0];
        count_d = count_q - 16'd1;
        if (count_q == 16'd1) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'd0) begin
          state_d = S_DONE;
          // misr_d already includes the final response, so pass is valid
          // in the same cycle as done.
          pass_d  = (misr_d == golden_q);
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && ((state_q == S_RUN) || (state_q == S_DRAIN))) begin
      state_d = S_IDLE;
      misr_d  = '0;
      pass_d  = 1'b0;
      vpipe_d = '0;
      count_d = '0;
      drain_d = '0;
    end
  end

  always_ff @(posedge tg_clk or posedge tg_rst) begin
    if (tg_rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      misr_q   <= '0;
      golden_q <= '0;
      count_q  <= '0;
      vpipe_q  <= '0;
      drain_q  <= '0;
      hold_q   <= SEED[N_IN-1:0];
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      golden_q <= golden_d;
      count_q  <= count_d;
      vpipe_q  <= vpipe_d;
      drain_q  <= drain_d;
      hold_q   <= hold_d;
      pass_q   <= pass_d;
    end
  end

endmodule

// File: tb/tb_subckt_stim_compactor.sv
module tb_subckt_stim_compactor;

  localparam int          L    = 2;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] POLY = 16'h1021;

  logic        tg_clk = 1'b0;
  logic        tg_rst;
  logic        start, abort;
  logic [15:0] num_vec, golden;
  logic [8:0]  stim;
  logic        stim_valid;
  logic [0:0]  resp;
  logic        busy, done, pass;
  logic [15:0] signature;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a run is described by its cycle index k since start.
  bit          m_active;
  int          m_k, m_n;
  logic [15:0] m_lfsr, m_misr, m_gold;
  logic        m_pass;
  logic [8:0]  m_last;

  always #5 tg_clk = ~tg_clk;

  subckt_stim_compactor #(
    .N_IN(9), .N_OUT(1), .LFSR_W(16), .SEED(SEED), .TAPS(TAPS),
    .MISR_W(16), .POLY(POLY), .RESP_LAT(L)
  ) dut (
    .tg_clk(tg_clk), .tg_rst(tg_rst), .start(start), .abort(abort),
    .num_vec(num_vec), .golden(golden), .stim(stim), .stim_valid(stim_valid),
    .resp(resp), .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] m, input logic r);
    return (m << 1) ^ (m[15] ? POLY : 16'h0000) ^ {15'h0000, r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Called at the falling edge: check this cycle's outputs, then advance the
  // model across the coming rising edge using the inputs now applied.
  task automatic model_cycle();
    logic       e_valid, e_busy, e_done;
    logic [8:0] e_stim;
    if (tg_rst) begin
      m_active = 0; m_k = 0; m_n = 0;
      m_misr = 16'h0; m_pass = 1'b0; m_lfsr = SEED; m_last = 9'(SEED);
    end
    e_valid = m_active && (m_k >= 1) && (m_k <= m_n);
    e_busy  = m_active && (m_k <= m_n + L);
    e_done  = m_active && (m_k == m_n + L + 1);
    if (e_done) m_pass = (m_misr == m_gold);
    e_stim  = e_valid ? m_lfsr[8:0] : m_last;
    chk("m_stim_valid", 32'(stim_valid), 32'(e_valid));
    chk("m_busy",       32'(busy),       32'(e_busy));
    chk("m_done",       32'(done),       32'(e_done));
    chk("m_stim",       32'(stim),       32'(e_stim));
    chk("m_signature",  32'(signature),  32'(m_misr));
    chk("m_pass",       32'(pass),       32'(m_pass));
    if (!tg_rst) begin
      if (!m_active) begin
        if (start && !abort) begin
          m_active = 1; m_k = 1; m_n = int'(num_vec); m_gold = golden;
          m_lfsr = SEED; m_misr = 16'h0; m_pass = 1'b0;
        end
      end else if (abort && e_busy) begin
        if (e_valid) m_last = m_lfsr[8:0];
        m_active = 0; m_misr = 16'h0; m_pass = 1'b0;
      end else begin
        if ((m_k >= L + 1) && (m_k <= L + m_n)) m_misr = misr_next(m_misr, resp[0]);
        if (e_valid) begin
          m_last = m_lfsr[8:0];
          m_lfsr = lfsr_next(m_lfsr);
        end
        if (e_done) m_active = 0;
        else m_k++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge tg_clk);
    model_cycle();
    @(posedge tg_clk);
    #1;
  endtask

  // Cycle 0 carries the start pulse; c = 1..maxc are observed afterwards.
  task automatic do_run(input int n, input logic [15:0] g, input int rmode,
                        input int abort_at, input int restart_at, input int maxc,
                        output int done_at, output int nvalid, output int ndone,
                        output logic [8:0] stim1, output logic [8:0] stim2,
                        output logic pass_done, output logic [31:0] busy_hist);
    done_at = -1; nvalid = 0; ndone = 0; stim1 = '0; stim2 = '0;
    pass_done = 1'b0; busy_hist = '0;
    start = 1'b1; abort = 1'b0; num_vec = 16'(n); golden = g;
    resp = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : 1'($urandom);
    cycle();
    for (int c = 1; c <= maxc; c++) begin
      if (stim_valid) begin
        nvalid++;
        if (nvalid == 1) stim1 = stim;
        if (nvalid == 2) stim2 = stim;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) begin done_at = c; pass_done = pass; end
      end
      if (c < 32) busy_hist[c] = busy;
      start = (c == restart_at);
      if (c == restart_at) num_vec = 16'd7;
      abort = (c == abort_at);
      resp = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : 1'($urandom);
      cycle();
    end
    start = 1'b0; abort = 1'b0;
  endtask

  int          done_at, nvalid, ndone;
  logic [8:0]  s1, s2;
  logic        pdone;
  logic [31:0] bh;

  initial begin
    tg_rst = 1'b1; start = 1'b0; abort = 1'b0;
    num_vec = '0; golden = '0; resp = '0;
    cycle(); cycle();
    chk("rst_stim", 32'(stim), 32'h0E1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sig",  32'(signature), 32'h0);
    tg_rst = 1'b0;
    cycle();

    // two vectors, zero responses
    do_run(2, 16'h0000, 0, -1, -1, 8, done_at, nvalid, ndone, s1, s2, pdone, bh);
    chk("t1_stim1",   32'(s1), 32'h0E1);
    chk("t1_stim2",   32'(s2), 32'h070);
    chk("t1_nvalid",  32'(nvalid), 32'd2);
    chk("t1_done_at", 32'(done_at), 32'd5);
    chk("t1_sig",     32'(signature), 32'h0000);

    // one vector, resp=1
    do_run(1, 16'h0001, 1, -1, -1, 8, done_at, nvalid, ndone, s1, s2, pdone, bh);
    chk("t2_done_at", 32'(done_at), 32'd4);
    chk("t2_sig",     32'(signature), 32'h0001);
    chk("t2_pass",    32'(pdone), 32'h1);
    chk("t2_pass_hold", 32'(pass), 32'h1);

    // two vectors, resp=1, start pulse during the DONE cycle must be ignored
    do_run(2, 16'h0002, 1, -1, 5, 12, done_at, nvalid, ndone, s1, s2, pdone, bh);
    chk("t3_sig",   32'(signature), 32'h0003);
    chk("t3_pass",  32'(pdone), 32'h0);
    chk("t3_ndone", 32'(ndone), 32'd1);

    // zero vectors
    do_run(0, 16'h0000, 1, -1, -1, 8, done_at, nvalid, ndone, s1, s2, pdone, bh);
    chk("t4_nvalid",  32'(nvalid), 32'd0);
    chk("t4_done_at", 32'(done_at), 32'd3);
    chk("t4_pass",    32'(pdone), 32'h1);

    // abort on the 4th RUN cycle
    do_run(10, 16'h0000, 2, 4, -1, 20, done_at, nvalid, ndone, s1, s2, pdone, bh);
    chk("t5_busy_k4", 32'(bh[4]), 32'h1);
    chk("t5_busy_k5", 32'(bh[5]), 32'h0);
    chk("t5_ndone",   32'(ndone), 32'd0);
    chk("t5_sig",     32'(signature), 32'h0);
    do_run(1, 16'h0000, 0, -1, -1, 8, done_at, nvalid, ndone, s1, s2, pdone, bh);
    chk("t5_fresh_stim", 32'(s1), 32'h0E1);
    chk("t5_fresh_done", 32'(done_at), 32'd4);

    // start and abort together in IDLE: no run
    start = 1'b1; abort = 1'b1; num_vec = 16'd5;
    cycle();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'h0);
    cycle();
    chk("sa_busy2", 32'(busy), 32'h0);

    // async reset in the middle of DRAIN
    start = 1'b1; num_vec = 16'd10; golden = 16'h0; resp = 1'b1;
    cycle();
    start = 1'b0;
    repeat (10) begin resp = 1'($urandom); cycle(); end
    chk("t6_in_drain", 32'({busy, stim_valid}), 32'b10);
    #2 tg_rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_stim", 32'(stim), 32'h0E1);
    chk("t6_rst_sig",  32'(signature), 32'h0);
    chk("t6_rst_done", 32'(done), 32'h0);
    cycle();
    tg_rst = 1'b0;
    do_run(3, 16'h0000, 2, -1, 2, 12, done_at, nvalid, ndone, s1, s2, pdone, bh);
    chk("t6_nvalid",  32'(nvalid), 32'd3);
    chk("t6_done_at", 32'(done_at), 32'd6);
    chk("t6_ndone",   32'(ndone), 32'd1);

    // longer run, random responses
    do_run(300, 16'h1234, 2, -1, -1, 320, done_at, nvalid, ndone, s1, s2, pdone, bh);
    chk("t7_nvalid",  32'(nvalid), 32'd300);
    chk("t7_done_at", 32'(done_at), 32'd303);

    // free-running random traffic
    for (int i = 0; i < 1500; i++) begin
      start   = ($urandom_range(0, 7) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      num_vec = 16'($urandom_range(0, 20));
      golden  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      resp    = 1'($urandom);
      cycle();
    end
    start = 1'b0; abort = 1'b0;
    repeat (30) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/subckt_stim_compactor.md
Name: subckt_stim_compactor

Overview:
- Self-contained exerciser for the benchmark sub-circuit netlists. It is the driving and observing end of the interface that a sub-circuit only consumes.
- Generates pseudo-random input vectors from a Galois LFSR and applies them one per cycle.
- Captures the sub-circuit's responses after a fixed pipeline latency and compacts them into a MISR signature.
- Compares the final signature against a golden value. Sits beside each sub-circuit instance in the trojan-detection test harness.

Parameters:
- N_IN, 9, stimulus vector width (≤ LFSR_W)
- N_OUT, 1, response width (≤ MISR_W)
- LFSR_W, 16, LFSR width
- SEED, 16'hACE1, LFSR reset/restart value (must be nonzero)
- TAPS, 16'hB400, Galois LFSR feedback mask
- MISR_W, 16, signature width
- POLY, 16'h1021, MISR feedback polynomial
- RESP_LAT, 2, cycles from stim_valid to the matching resp sample (1..8)

Ports:
- tg_clk  in  1  sole clock, rising edge
- tg_rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run (honoured only in IDLE)
- abort  in  1  synchronous; cancels a run and returns to IDLE
- num_vec  in  16  vectors per run, sampled at the start pulse
- golden  in  MISR_W  expected signature, sampled at the start pulse
- stim  out  N_IN  vector to the sub-circuit inputs
- stim_valid  out  1  stim holds a new vector this cycle
- resp  in  N_OUT  sub-circuit output
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at run completion
- pass  out  1  signature == golden; valid from the done pulse until the next start
- signature  out  MISR_W  current MISR value

Behaviour:
- Reset (async, tg_rst=1):
  - FSM=IDLE, lfsr=SEED, misr=0, count=0, valid pipe=0.
  - stim=SEED[N_IN-1:0], stim_valid=0, busy=0, done=0, pass=0, signature=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start, load count=num_vec, latch golden, set lfsr=SEED and misr=0.
  - Go to RUN, or to DRAIN if num_vec==0.
- RUN:
  - stim_valid=1 every cycle; stim=lfsr[N_IN-1:0].
  - lfsr advances each RUN cycle: lsb ? (lfsr>>1)^TAPS : lfsr>>1.
  - count decrements; on the cycle count reaches 1, next state is DRAIN.
  - The first vector appears the cycle after start.
- Valid pipe:
  - RESP_LAT-deep shift register of stim_valid.
  - When its tail is 1, the MISR updates: misr = (misr<<1) ^ (misr[MSB] ? POLY : 0) ^ zero_ext(resp).
  - The pipe keeps shifting in DRAIN with input 0.
- DRAIN:
  - stim_valid=0; stim holds its last value.
  - Exit to DONE when the valid pipe is all zero, i.e. RESP_LAT cycles after the last vector.
- DONE (exactly one cycle):
  - done=1; pass registered as (misr == golden); then return to IDLE.
- signature and pass hold until the next accepted start.
- Totals:
  - Run length from start to done = num_vec + RESP_LAT + 1 cycles.
  - MISR updates = num_vec exactly.
- Boundary cases:
  - start while busy or in DONE: ignored.
  - start and abort in the same IDLE cycle: abort wins; no run.
  - abort in RUN or DRAIN: → IDLE next cycle; no done; misr cleared to 0; pass=0; valid pipe flushed.
  - num_vec==0: no stim_valid; done after RESP_LAT+1 cycles; signature=0; pass = (golden==0).
  - num_vec==16'hFFFF: count is 16-bit, no wrap; exactly 65535 vectors.
  - Asynchronous reset mid-run: immediate return to reset values; no done.
- The LFSR never reaches zero given a nonzero SEED.
- All arithmetic is modulo 2; there are no counters wider than 16 bits.

Test Plan:
- Reset then start, num_vec=2, resp=0 → stim=0x0E1 then 0x070 (lfsr 0xACE1→0xE270); stim_valid high for 2 cycles; done 5 cycles after start; signature=0x0000.
- resp tied 1, num_vec=1, golden=0x0001 → one MISR update; signature=0x0001; pass=1 with done.
- resp tied 1, num_vec=2, golden=0x0002 → signature=0x0003; pass=0; done exactly once.
- num_vec=0, golden=0 → no stim_valid; done 3 cycles after start; pass=1.
- num_vec=10; abort on the 4th RUN cycle → busy falls the next cycle; no done; signature=0. A following start with num_vec=1 behaves as on a fresh reset (first stim 0x0E1).
- num_vec=10; assert tg_rst asynchronously mid-DRAIN → outputs reach reset values before the next edge; a start pulse during busy in a later run is ignored.
